// File: rtl/mem_access_unit.sv
// Memory stage: issues one data-memory access per load/store, stalls upstream
// until the memory acks, and registers the MEM/WB pipeline fields.
//
// state   | meaning
// ST_IDLE | no access in flight; aligned mem op issues a request at the next edge
// ST_WAIT | request held on dmem_*, waiting for the one-cycle dmem_ack
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_in,
  input  logic [4:0]  dest_addr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] imm_in,
  input  logic [1:0]  wb_sel_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] read_data2_in,
  input  logic [3:0]  mem_read_in,
  input  logic [2:0]  mem_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        reg_write_out,
  output logic [4:0]  dest_addr_out,
  output logic [31:0] pc_out,
  output logic [31:0] imm_out,
  output logic [1:0]  wb_sel_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] load_data_out,
  output logic        misaligned_out
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state, state_nxt;
  logic        is_store, is_load, mem_op, misaligned, aligned_op, ack_done;
  logic [1:0]  acc_size;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, ld_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A store wins when both enables are set; the load half is dropped.
  assign is_store = mem_write_in[2];
  assign is_load  = mem_read_in[3] & ~is_store;
  assign mem_op   = mem_read_in[3] | mem_write_in[2];

  // Size code 00 byte, 01 half, 1x word; unused load funct3 values fall to word.
  assign acc_size = is_store ? mem_write_in[1:0]
                  : (mem_read_in[1] ? 2'b10 : {1'b0, mem_read_in[0]});

  assign misaligned = mem_op & (((acc_size == 2'b01) & alu_result_in[0]) |
                                (acc_size[1] & (alu_result_in[1:0] != 2'b00)));
  assign aligned_op = mem_op & ~misaligned;
  assign ack_done   = (state == ST_WAIT) & dmem_ack;
  assign stall      = aligned_op & ~ack_done;

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = read_data2_in;
    case (acc_size)
      2'b00: begin
        be_nxt    = 4'b0001 << alu_result_in[1:0];
        wdata_nxt = {4{read_data2_in[7:0]}};
      end
      2'b01: begin
        be_nxt    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{read_data2_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (alu_result_in[1:0])
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      2'b11:   byte_sel = dmem_rdata[31:24];
      default: ;
    endcase
    half_sel = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_read_in[2:0])
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_ext = {24'h0, byte_sel};
      3'b101:  ld_ext = {16'h0, half_sel};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (aligned_op) state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_ack)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured once on entry to ST_WAIT and held until ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'h0;
    end else if ((state == ST_IDLE) && aligned_op) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store;
      dmem_addr  <= {alu_result_in[31:2], 2'b00};
      dmem_wdata <= wdata_nxt;
      dmem_be    <= is_store ? be_nxt : 4'h0;
    end else if (ack_done) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_out  <= 1'b0;
      dest_addr_out  <= 5'h0;
      pc_out         <= 32'h0;
      imm_out        <= 32'h0;
      wb_sel_out     <= 2'h0;
      alu_result_out <= 32'h0;
      load_data_out  <= 32'h0;
      misaligned_out <= 1'b0;
    end else if (stall) begin
      reg_write_out  <= 1'b0;
      misaligned_out <= 1'b0;
    end else begin
      reg_write_out  <= reg_write_in & ~is_store & ~misaligned;
      dest_addr_out  <= dest_addr_in;
      pc_out         <= pc_in;
      imm_out        <= imm_in;
      wb_sel_out     <= wb_sel_in;
      alu_result_out <= alu_result_in;
      misaligned_out <= misaligned;
      if (ack_done && is_load) load_data_out <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single ops with a
// scripted memory ack delay, plus reset/ack corner sequences.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_in;
  logic [4:0]  dest_addr_in;
  logic [31:0] pc_in, imm_in, alu_result_in, read_data2_in;
  logic [1:0]  wb_sel_in;
  logic [3:0]  mem_read_in;
  logic [2:0]  mem_write_in;
  logic        dmem_req, dmem_we, dmem_ack, stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        reg_write_out, misaligned_out;
  logic [4:0]  dest_addr_out;
  logic [31:0] pc_out, imm_out, alu_result_out, load_data_out;
  logic [1:0]  wb_sel_out;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .reg_write_in(reg_write_in), .dest_addr_in(dest_addr_in), .pc_in(pc_in),
    .imm_in(imm_in), .wb_sel_in(wb_sel_in), .alu_result_in(alu_result_in),
    .read_data2_in(read_data2_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall),
    .reg_write_out(reg_write_out), .dest_addr_out(dest_addr_out), .pc_out(pc_out),
    .imm_out(imm_out), .wb_sel_out(wb_sel_out), .alu_result_out(alu_result_out),
    .load_data_out(load_data_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [3:0]  mr;
    logic [2:0]  mw;
    logic [31:0] rdata;
    int          delay;
    int          exp_stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_rw;
    logic        exp_mis;
    logic        chk_ld;
    logic [31:0] exp_ld;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
      input logic [31:0] sdata, input logic [3:0] mr, input logic [2:0] mw,
      input logic [31:0] rdata, input int delay, input int exp_stall, input logic exp_req,
      input logic [31:0] exp_addr, input logic exp_we, input logic [3:0] exp_be,
      input logic [31:0] exp_wdata, input logic exp_rw, input logic exp_mis,
      input logic chk_ld, input logic [31:0] exp_ld);
    vec_t v;
    v.rw = rw; v.rd = rd; v.alu = alu; v.sdata = sdata; v.mr = mr; v.mw = mw;
    v.rdata = rdata; v.delay = delay; v.exp_stall = exp_stall; v.exp_req = exp_req;
    v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.exp_rw = exp_rw; v.exp_mis = exp_mis; v.chk_ld = chk_ld; v.exp_ld = exp_ld;
    return v;
  endfunction

  task automatic set_in(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
      input logic [31:0] sdata, input logic [3:0] mr, input logic [2:0] mw, input int tag);
    reg_write_in  = rw;
    dest_addr_in  = rd;
    alu_result_in = alu;
    read_data2_in = sdata;
    mem_read_in   = mr;
    mem_write_in  = mw;
    pc_in         = 32'h1000 + 32'(tag) * 4;
    imm_in        = 32'(tag) + 32'h100;
    wb_sel_in     = 2'(tag);
  endtask

  initial begin
    int   stall_cnt, wait_cnt;
    logic stall_s, req_seen, done;
    //           rw rd   alu            sdata          mr       mw      rdata          dly stl req addr          we be       wdata          rw mis ld  exp_ld
    vecs[0]  = mk(1, 5,  32'h00000003, 32'h0,         4'b0000, 3'b000, 32'h0,         0, 0, 0, 32'h0,       0, 4'h0,    32'h0,         1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 7,  32'h00000103, 32'h0,         4'b1000, 3'b000, 32'h80FF0011,  3, 4, 1, 32'h00000100, 0, 4'h0,   32'h0,         1, 0, 1, 32'hFFFFFF80);
    vecs[2]  = mk(1, 8,  32'h00000102, 32'h0,         4'b1101, 3'b000, 32'hBEEF1234,  0, 1, 1, 32'h00000100, 0, 4'h0,   32'h0,         1, 0, 1, 32'h0000BEEF);
    vecs[3]  = mk(1, 9,  32'h00000102, 32'h0,         4'b1001, 3'b000, 32'hBEEF1234,  1, 2, 1, 32'h00000100, 0, 4'h0,   32'h0,         1, 0, 1, 32'hFFFFBEEF);
    vecs[4]  = mk(0, 10, 32'h00000201, 32'h000000AB,  4'b0000, 3'b100, 32'h0,         2, 3, 1, 32'h00000200, 1, 4'b0010, 32'hABABABAB,  0, 0, 0, 32'h0);
    vecs[5]  = mk(0, 11, 32'h00000202, 32'h1234CDEF,  4'b0000, 3'b101, 32'h0,         0, 1, 1, 32'h00000200, 1, 4'b1100, 32'hCDEFCDEF,  0, 0, 0, 32'h0);
    vecs[6]  = mk(0, 12, 32'h00000300, 32'hDEADBEEF,  4'b0000, 3'b110, 32'h0,         1, 2, 1, 32'h00000300, 1, 4'b1111, 32'hDEADBEEF,  0, 0, 0, 32'h0);
    vecs[7]  = mk(1, 13, 32'h00000006, 32'h0,         4'b1010, 3'b000, 32'h0,         0, 0, 0, 32'h0,       0, 4'h0,    32'h0,         0, 1, 0, 32'h0);
    vecs[8]  = mk(1, 14, 32'h00000101, 32'h0,         4'b1100, 3'b000, 32'h11229944,  0, 1, 1, 32'h00000100, 0, 4'h0,   32'h0,         1, 0, 1, 32'h00000099);
    vecs[9]  = mk(1, 15, 32'h00000400, 32'h0,         4'b1011, 3'b000, 32'h87654321,  0, 1, 1, 32'h00000400, 0, 4'h0,   32'h0,         1, 0, 1, 32'h87654321);
    vecs[10] = mk(1, 16, 32'h00000500, 32'h01020304,  4'b1000, 3'b110, 32'h0,         0, 1, 1, 32'h00000500, 1, 4'b1111, 32'h01020304,  0, 0, 0, 32'h0);
    vecs[11] = mk(0, 17, 32'h00000203, 32'h00005555,  4'b0000, 3'b101, 32'h0,         0, 0, 0, 32'h0,       0, 4'h0,    32'h0,         0, 1, 0, 32'h0);
    vecs[12] = mk(1, 18, 32'h00000100, 32'h0,         4'b1000, 3'b000, 32'h000000F0,  0, 1, 1, 32'h00000100, 0, 4'h0,   32'h0,         1, 0, 1, 32'hFFFFFFF0);
    vecs[13] = mk(1, 19, 32'h12345678, 32'h0,         4'b0000, 3'b000, 32'h0,         0, 0, 0, 32'h0,       0, 4'h0,    32'h0,         1, 0, 0, 32'h0);

    // reset: outputs cleared, stall still reflects an aligned load on the inputs
    rst = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    set_in(1, 5'd4, 32'h00000103, 32'h0, 4'b1000, 3'b000, 99);
    #12;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_rw", 32'(reg_write_out), 32'd0);
    chk("rst_alu", alu_result_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_ld", load_data_out, 32'h0);
    set_in(0, 5'd0, 32'h0, 32'h0, 4'b0000, 3'b000, 98);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].rw, vecs[i].rd, vecs[i].alu, vecs[i].sdata, vecs[i].mr, vecs[i].mw, i);
      stall_cnt = 0;
      wait_cnt  = 0;
      req_seen  = 1'b0;
      done      = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
        @(negedge clk);
        if (dmem_req) begin
          req_seen = 1'b1;
          chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].exp_addr);
          chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].exp_we));
          if (vecs[i].exp_we) begin
            chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].exp_be));
            chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
          end
          if (wait_cnt == vecs[i].delay) begin
            dmem_ack   = 1'b1;
            dmem_rdata = vecs[i].rdata;
          end else begin
            wait_cnt++;
          end
        end
        #1;
        stall_s = stall;
        if (stall_s) stall_cnt++;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        if (!stall_s) done = 1'b1;
        else begin
          chk($sformatf("v%0d_bubble_rw", i), 32'(reg_write_out), 32'd0);
          chk($sformatf("v%0d_bubble_mis", i), 32'(misaligned_out), 32'd0);
        end
      end
      if (!done) chk($sformatf("v%0d_timeout", i), 32'd1, 32'd0);
      chk($sformatf("v%0d_stall_cycles", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_req_seen", i), 32'(req_seen), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_req_after", i), 32'(dmem_req), 32'd0);
      chk($sformatf("v%0d_rw", i), 32'(reg_write_out), 32'(vecs[i].exp_rw));
      chk($sformatf("v%0d_mis", i), 32'(misaligned_out), 32'(vecs[i].exp_mis));
      chk($sformatf("v%0d_rd", i), 32'(dest_addr_out), 32'(vecs[i].rd));
      chk($sformatf("v%0d_alu", i), alu_result_out, vecs[i].alu);
      chk($sformatf("v%0d_pc", i), pc_out, 32'h1000 + 32'(i) * 4);
      chk($sformatf("v%0d_imm", i), imm_out, 32'(i) + 32'h100);
      if (vecs[i].chk_ld) chk($sformatf("v%0d_ld", i), load_data_out, vecs[i].exp_ld);
    end

    // reset during WAIT abandons the access; a late ack in IDLE is ignored
    set_in(1, 5'd2, 32'h00000010, 32'h0, 4'b1010, 3'b000, 50);
    @(posedge clk);
    #1;
    chk("wrst_req_before", 32'(dmem_req), 32'd1);
    chk("wrst_addr_before", dmem_addr, 32'h00000010);
    #2;
    rst = 1'b0;
    #1;
    chk("wrst_req", 32'(dmem_req), 32'd0);
    chk("wrst_addr", dmem_addr, 32'h0);
    chk("wrst_rw", 32'(reg_write_out), 32'd0);
    chk("wrst_alu", alu_result_out, 32'h0);
    chk("wrst_ld", load_data_out, 32'h0);
    chk("wrst_stall_ld", 32'(stall), 32'd1);
    set_in(1, 5'd3, 32'h00000009, 32'h0, 4'b0000, 3'b000, 51);
    #1;
    chk("wrst_stall_add", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("late_ack_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    chk("late_ack_ld", load_data_out, 32'h0);
    chk("post_rst_alu", alu_result_out, 32'h00000009);
    chk("post_rst_rd", 32'(dest_addr_out), 32'd3);
    chk("post_rst_rw", 32'(reg_write_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
